prio_grant_sequencer: RTL and testbench

- Sequential counterpart of the combinational priority-select logic in the mcnc91 set.
- That logic collapses an 8-lane request vector into a single priority-selected result in one evaluation.
- This block takes a captured 8-lane request vector plus lane data and replays it as a stream of one-hot grants, lowest index first, one beat per accepted handshake.
- Sits between a request collector (upstream valid/ready) and a per-lane consumer (downstream valid/ready).

---
 rtl/prio_grant_pkg.sv | 27 ++
 rtl/prio_lowbit_enc.sv | 36 +++
 rtl/prio_grant_sequencer.sv | 118 +++++++++++
 tb/tb_prio_grant_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/prio_grant_pkg.sv
// Shared types and helpers for the priority-grant sequencer family.
// Functions work on a 16-lane vector; narrower users zero-extend.
package prio_grant_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  localparam int CNT_W     = 16;
  localparam int MAX_LANES = 16;

  // Isolates the lowest set bit (vec & -vec); all-zero in, all-zero out.
  function automatic logic [MAX_LANES-1:0] lowest_onehot(input logic [MAX_LANES-1:0] vec);
    return vec & (~vec + MAX_LANES'(1));
  endfunction

  function automatic logic [3:0] onehot_to_idx(input logic [MAX_LANES-1:0] onehot);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (onehot[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_lowbit_enc.sv
// Combinational lowest-set-bit encoder: one-hot grant, its index, and
// whether any other bit remains once the granted bit is removed.
module prio_lowbit_enc #(
  parameter int LANES = 8,
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic [LANES-1:0] vec,
  output logic [LANES-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             rest_zero
);

  // below[i] is set when any lane lower than i is requesting.
  logic [LANES-1:0]            below;
  logic [IDX_W-1:0][LANES-1:0] idx_terms;

  assign below[0] = 1'b0;

  genvar gi, bi;
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    assign grant[gi] = vec[gi] & ~below[gi];
    if (gi < LANES - 1) begin : g_chain
      assign below[gi+1] = below[gi] | vec[gi];
    end
  end

  for (bi = 0; bi < IDX_W; bi++) begin : g_idx_bit
    for (gi = 0; gi < LANES; gi++) begin : g_term
      assign idx_terms[bi][gi] = (((gi >> bi) & 1) == 1) ? grant[gi] : 1'b0;
    end
    assign idx[bi] = |idx_terms[bi];
  end

  assign rest_zero = ~|(vec & ~grant);

endmodule

// File: rtl/prio_grant_sequencer.sv
// Replays a captured request vector as one-hot grant beats, lowest lane first.
// Optional saturating beat counter enabled by PRIO_GRANT_SEQ_COUNT_EN.
module prio_grant_sequencer
  import prio_grant_pkg::*;
#(
  parameter int LANES = 8,
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] in_req,
  input  logic [LANES-1:0] in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] out_grant,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_data,
  output logic             out_last,
  output logic             out_null
`ifdef PRIO_GRANT_SEQ_COUNT_EN
  ,
  output logic [CNT_W-1:0] beat_cnt,
  input  logic             cnt_clr
`endif
);

  state_e           state_reg, state_next;
  logic [LANES-1:0] pend_reg, pend_next;
  logic [LANES-1:0] dreg_reg, dreg_next;
  logic             inv_reg, inv_next;

  logic [LANES-1:0] enc_grant;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_rest_zero;

  prio_lowbit_enc #(
    .LANES(LANES),
    .IDX_W(IDX_W)
  ) u_enc (
    .vec      (pend_reg),
    .grant    (enc_grant),
    .idx      (enc_idx),
    .rest_zero(enc_rest_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pend_reg  <= '0;
      dreg_reg  <= '0;
      inv_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      dreg_reg  <= dreg_next;
      inv_reg   <= inv_next;
    end
  end

  // Outputs decode only registered state, so in_* and out_ready never
  // reach out_* or in_ready combinationally.
  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    dreg_next  = dreg_reg;
    inv_next   = inv_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_grant  = '0;
    out_idx    = '0;
    out_data   = 1'b0;
    out_last   = 1'b0;
    out_null   = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pend_next  = in_req;
          dreg_next  = in_data;
          inv_next   = in_inv;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        out_valid = 1'b1;
        out_grant = enc_grant;
        out_idx   = enc_idx;
        out_last  = enc_rest_zero;
        out_null  = ~|pend_reg;
        if (|pend_reg) out_data = dreg_reg[enc_idx] ^ inv_reg;
        if (out_ready) begin
          pend_next = pend_reg & ~enc_grant;
          if (enc_rest_zero) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef PRIO_GRANT_SEQ_COUNT_EN
  logic [CNT_W-1:0] beat_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      beat_cnt_reg <= '0;
    end else if (out_valid && out_ready && (beat_cnt_reg != {CNT_W{1'b1}})) begin
      beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
    end
  end

  assign beat_cnt = beat_cnt_reg;
`endif

endmodule

// File: tb/tb_prio_grant_sequencer.sv
// Directed, table-driven bench for prio_grant_sequencer (8 lanes).
// Counter checks are compiled in when PRIO_GRANT_SEQ_COUNT_EN is defined.
module tb_prio_grant_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_req;
  logic [7:0] in_data;
  logic       in_inv;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_grant;
  logic [2:0] out_idx;
  logic       out_data;
  logic       out_last;
  logic       out_null;
`ifdef PRIO_GRANT_SEQ_COUNT_EN
  logic [15:0] beat_cnt;
  logic        cnt_clr;
`endif

  int total = 0;
  int bad   = 0;

  prio_grant_sequencer #(.LANES(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_req   (in_req),
    .in_data  (in_data),
    .in_inv   (in_inv),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_grant(out_grant),
    .out_idx  (out_idx),
    .out_data (out_data),
    .out_last (out_last),
    .out_null (out_null)
`ifdef PRIO_GRANT_SEQ_COUNT_EN
    ,
    .beat_cnt (beat_cnt),
    .cnt_clr  (cnt_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  req;
    logic [7:0]  data;
    logic        inv;
    logic        stall;     // out_ready follows 1,0,0,1,... instead of 1
    int          nbeats;
    logic [31:0] idx_seq;   // nibble k = lane index of beat k
    logic [7:0]  data_seq;  // bit k = out_data of beat k
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_grant"},     32'(out_grant), 32'd0);
    chk({tag, "_idx"},       32'(out_idx),   32'd0);
    chk({tag, "_data"},      32'(out_data),  32'd0);
    chk({tag, "_last"},      32'(out_last),  32'd0);
    chk({tag, "_null"},      32'(out_null),  32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the last beat.
  task automatic run_word(input vec_t v);
    int         beat;
    int         cyc;
    logic       rdy;
    logic [2:0] e_idx;
    logic [7:0] e_grant;
    logic       e_null;
    chk("pre_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_req   = v.req;
    in_data  = v.data;
    in_inv   = v.inv;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_req   = 8'h00;
    in_data  = 8'h00;
    in_inv   = 1'b0;
    e_null = (v.req == 8'h00);
    beat = 0;
    cyc  = 0;
    while (beat < v.nbeats && cyc < 64) begin
      rdy = v.stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      out_ready = rdy;
      e_idx   = v.idx_seq[4*beat +: 3];
      e_grant = e_null ? 8'h00 : (8'h01 << e_idx);
      chk("beat_valid",    32'(out_valid), 32'd1);
      chk("beat_in_ready", 32'(in_ready),  32'd0);
      chk("beat_grant",    32'(out_grant), 32'(e_grant));
      chk("beat_idx",      32'(out_idx),   32'(e_idx));
      chk("beat_data",     32'(out_data),  32'(v.data_seq[beat]));
      chk("beat_last",     32'(out_last),  32'(beat == v.nbeats - 1));
      chk("beat_null",     32'(out_null),  32'(e_null));
      @(negedge clk);
      if (rdy) beat++;
      cyc++;
    end
    out_ready = 1'b0;
    chk("word_beat_count", 32'(beat), 32'(v.nbeats));
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready",  32'(in_ready),  32'd1);
    $display("word req=%02h data=%02h inv=%0d stall=%0d beats=%0d cycles=%0d",
             v.req, v.data, v.inv, v.stall, beat, cyc);
  endtask

  initial begin
    vecs[0] = '{req: 8'hA4, data: 8'h84, inv: 1'b0, stall: 1'b0, nbeats: 3, idx_seq: 32'h0000_0752, data_seq: 8'h05};
    vecs[1] = '{req: 8'hA4, data: 8'h84, inv: 1'b1, stall: 1'b1, nbeats: 3, idx_seq: 32'h0000_0752, data_seq: 8'h02};
    vecs[2] = '{req: 8'h00, data: 8'hFF, inv: 1'b1, stall: 1'b0, nbeats: 1, idx_seq: 32'h0000_0000, data_seq: 8'h00};
    vecs[3] = '{req: 8'hFF, data: 8'h5A, inv: 1'b0, stall: 1'b0, nbeats: 8, idx_seq: 32'h7654_3210, data_seq: 8'h5A};
    vecs[4] = '{req: 8'h81, data: 8'h01, inv: 1'b1, stall: 1'b1, nbeats: 2, idx_seq: 32'h0000_0070, data_seq: 8'h02};
    vecs[5] = '{req: 8'h10, data: 8'h10, inv: 1'b0, stall: 1'b0, nbeats: 1, idx_seq: 32'h0000_0004, data_seq: 8'h01};

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_req    = 8'hFF;
    in_data   = 8'hFF;
    in_inv    = 1'b0;
    out_ready = 1'b1;
`ifdef PRIO_GRANT_SEQ_COUNT_EN
    cnt_clr   = 1'b0;
`endif

    // Reset held with a pending upstream word: nothing may be captured.
    repeat (3) @(negedge clk);
    chk_idle_outputs("in_reset");
    rst_n    = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk_idle_outputs("after_reset");
    $display("reset released");

    for (int i = 0; i < 6; i++) run_word(vecs[i]);

    // in_valid held high across a last beat: no acceptance in that cycle.
    in_valid = 1'b1;
    in_req   = 8'h02;
    in_data  = 8'h02;
    in_inv   = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    chk("ovl_last",     32'(out_last), 32'd1);
    chk("ovl_idx",      32'(out_idx),  32'd1);
    chk("ovl_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("ovl_gap_valid", 32'(out_valid), 32'd0);
    chk("ovl_gap_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ovl_second_valid", 32'(out_valid), 32'd1);
    chk("ovl_second_data",  32'(out_data),  32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    chk("ovl_done_valid", 32'(out_valid), 32'd0);
    $display("overlap sequence done");

    // Reset asserted while the 4th beat of an all-ones word is presented.
    in_valid = 1'b1;
    in_req   = 8'hFF;
    in_data  = 8'hFF;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_idx",   32'(out_idx),   32'd3);
    chk("mid_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_outputs("mid_rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("mid_rst_after");
    out_ready = 1'b0;
    $display("mid-word reset done");

`ifdef PRIO_GRANT_SEQ_COUNT_EN
    // Stream well over 65535 beats; the counter must park at FFFF.
    in_valid  = 1'b1;
    in_req    = 8'hFF;
    in_data   = 8'h00;
    out_ready = 1'b1;
    repeat (8192 * 9 + 18) @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("cnt_saturate", 32'(beat_cnt), 32'h0000_FFFF);
    $display("counter stream done cnt=%04h", beat_cnt);

    in_valid = 1'b1;
    in_req   = 8'h03;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    chk("cnt_clr_beat_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("cnt_clr_wins", 32'(beat_cnt), 32'd0);
    @(negedge clk);
    chk("cnt_after_clr", 32'(beat_cnt), 32'd1);
    out_ready = 1'b0;
    $display("counter clear done");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
